// File: rtl/ysyx_22041211_core_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencer.
//   state_e        : sequencer state encoding
//   BRANCH_*       : decoder branch_type codes
//   STORE_INVALID  : decoder store_type code meaning "not a store"
//   LOAD_INVALID   : decoder load_type code meaning "not a load"
package ysyx_22041211_core_ctrl_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ST_TYPE_W = 2;
  localparam int unsigned LD_TYPE_W = 3;
  localparam int unsigned BR_TYPE_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF   = 3'd1,
    ST_ID   = 3'd2,
    ST_EX   = 3'd3,
    ST_MEM  = 3'd4,
    ST_WB   = 3'd5,
    ST_HALT = 3'd6,
    ST_ERR  = 3'd7
  } state_e;

  localparam logic [BR_TYPE_W-1:0] BRANCH_NONE   = BR_TYPE_W'(0);
  localparam logic [BR_TYPE_W-1:0] BRANCH_BEQ    = BR_TYPE_W'(1);
  localparam logic [ST_TYPE_W-1:0] STORE_INVALID = ST_TYPE_W'(0);
  localparam logic [LD_TYPE_W-1:0] LOAD_INVALID  = LD_TYPE_W'(0);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

endpackage

// File: rtl/ysyx_22041211_pc_reg.sv
// Program counter register.
//   clk, rst_n : clock, async active-low reset (loads RESET_PC)
//   i_we       : load i_next_pc on the next edge
//   i_next_pc  : next PC value
//   o_pc       : current PC
module ysyx_22041211_pc_reg
  import ysyx_22041211_core_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [XLEN-1:0] i_next_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_we) begin
      r_pc <= i_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_22041211_core_ctrl.sv
// Multi-cycle sequencer: owns PC and instruction register, drives the fetch
// and LSU handshakes, gates register writeback and counts retirements.
//   ifu_*  : fetch request / returned instruction
//   pc_o, inst_o : current PC and held instruction (to IFU / decoder)
//   dec_*, alu_zero_i, ebreak_i : decoder and ALU status for current inst
//   lsu_*  : memory request, direction and completion
//   reg_we_o, wb_sel_o : register-file write strobe and source select
//   commit_o, inst_cnt_o : retire pulse and retired count
//   halted_o, err_o : sticky stop flags (ebreak / misaligned target)
module ysyx_22041211_core_ctrl
  import ysyx_22041211_core_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ifu_req_o,
  input  logic                 ifu_rvalid_i,
  input  logic [XLEN-1:0]      ifu_inst_i,
  output logic [XLEN-1:0]      pc_o,
  output logic [XLEN-1:0]      inst_o,
  input  logic                 dec_wd_i,
  input  logic [ST_TYPE_W-1:0] dec_store_type_i,
  input  logic [LD_TYPE_W-1:0] dec_load_type_i,
  input  logic [BR_TYPE_W-1:0] dec_branch_type_i,
  input  logic [XLEN-1:0]      dec_branch_target_i,
  input  logic                 dec_jmp_flag_i,
  input  logic [XLEN-1:0]      dec_jmp_target_i,
  input  logic                 alu_zero_i,
  input  logic                 ebreak_i,
  output logic                 lsu_req_o,
  output logic                 lsu_we_o,
  input  logic                 lsu_done_i,
  output logic                 reg_we_o,
  output logic                 wb_sel_o,
  output logic                 commit_o,
  output logic                 halted_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     inst_cnt_o
);

  state_e          r_state;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_next_pc;
  logic [CNT_W-1:0] r_inst_cnt;
  logic            r_ifu_req;
  logic            r_lsu_req;
  logic            r_lsu_we;
  logic            r_reg_we;
  logic            r_wb_sel;
  logic            r_commit;
  logic            r_halted;
  logic            r_err;

  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_jmp_pc;
  logic [XLEN-1:0] w_next_pc;
  logic            w_beq_taken;
  logic            w_misalign;
  logic            w_is_store;
  logic            w_is_load;
  logic            w_reg_we;
  logic            w_pc_we;
  logic            w_unused;

  ysyx_22041211_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_pc_we),
    .i_next_pc (r_next_pc),
    .o_pc      (w_pc)
  );

  // Next-PC selection: jump beats taken beq beats sequential.
  assign w_pc_plus4  = w_pc + PC_STEP;
  assign w_jmp_pc    = {dec_jmp_target_i[XLEN-1:1], 1'b0};
  assign w_beq_taken = (dec_branch_type_i == BRANCH_BEQ) && alu_zero_i;
  assign w_next_pc   = dec_jmp_flag_i ? w_jmp_pc :
                       w_beq_taken    ? dec_branch_target_i : w_pc_plus4;
  assign w_misalign  = |w_next_pc[1:0];

  assign w_is_store  = (dec_store_type_i != STORE_INVALID);
  assign w_is_load   = (dec_load_type_i != LOAD_INVALID);
  assign w_reg_we    = dec_wd_i && !w_is_store;
  assign w_pc_we     = (r_state == ST_WB);
  // jalr clears bit 0 of the target, so the raw bit is never consumed.
  assign w_unused    = dec_jmp_target_i[0];

  // Sequencer; every output is set on entry to the state that owns it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_inst     <= '0;
      r_next_pc  <= '0;
      r_inst_cnt <= '0;
      r_ifu_req  <= 1'b0;
      r_lsu_req  <= 1'b0;
      r_lsu_we   <= 1'b0;
      r_reg_we   <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_commit   <= 1'b0;
      r_halted   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state   <= ST_IF;
          r_ifu_req <= 1'b1;
        end
        ST_IF: begin
          if (ifu_rvalid_i) begin
            r_inst    <= ifu_inst_i;
            r_ifu_req <= 1'b0;
            r_state   <= ST_ID;
          end
        end
        ST_ID: begin
          if (ebreak_i) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_state  <= ST_EX;
          end
        end
        ST_EX: begin
          r_next_pc <= w_next_pc;
          if (w_misalign) begin
            r_halted <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= ST_ERR;
          end else if (w_is_store || w_is_load) begin
            r_lsu_req <= 1'b1;
            r_lsu_we  <= w_is_store;
            r_state   <= ST_MEM;
          end else begin
            r_reg_we <= w_reg_we;
            r_wb_sel <= w_is_load;
            r_commit <= 1'b1;
            r_state  <= ST_WB;
          end
        end
        ST_MEM: begin
          if (lsu_done_i) begin
            r_lsu_req <= 1'b0;
            r_lsu_we  <= 1'b0;
            r_reg_we  <= w_reg_we;
            r_wb_sel  <= w_is_load;
            r_commit  <= 1'b1;
            r_state   <= ST_WB;
          end
        end
        ST_WB: begin
          r_reg_we   <= 1'b0;
          r_wb_sel   <= 1'b0;
          r_commit   <= 1'b0;
          r_inst_cnt <= r_inst_cnt + CNT_W'(1);
          r_ifu_req  <= 1'b1;
          r_state    <= ST_IF;
        end
        ST_HALT, ST_ERR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ifu_req_o  = r_ifu_req;
  assign pc_o       = w_pc;
  assign inst_o     = r_inst;
  assign lsu_req_o  = r_lsu_req;
  assign lsu_we_o   = r_lsu_we;
  assign reg_we_o   = r_reg_we;
  assign wb_sel_o   = r_wb_sel;
  assign commit_o   = r_commit;
  assign halted_o   = r_halted;
  assign err_o      = r_err;
  assign inst_cnt_o = r_inst_cnt;

endmodule

// File: tb/tb_ysyx_22041211_core_ctrl.sv
// Self-checking bench for ysyx_22041211_core_ctrl: directed and random
// instruction streams against an instruction-level reference model.
module tb_ysyx_22041211_core_ctrl;
  import ysyx_22041211_core_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_o, ifu_rvalid_i;
  logic [31:0] ifu_inst_i, pc_o, inst_o;
  logic        dec_wd_i;
  logic [1:0]  dec_store_type_i;
  logic [2:0]  dec_load_type_i, dec_branch_type_i;
  logic [31:0] dec_branch_target_i, dec_jmp_target_i;
  logic        dec_jmp_flag_i, alu_zero_i, ebreak_i;
  logic        lsu_req_o, lsu_we_o, lsu_done_i;
  logic        reg_we_o, wb_sel_o, commit_o, halted_o, err_o;
  logic [31:0] inst_cnt_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  ysyx_22041211_core_ctrl #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_o(ifu_req_o), .ifu_rvalid_i(ifu_rvalid_i), .ifu_inst_i(ifu_inst_i),
    .pc_o(pc_o), .inst_o(inst_o),
    .dec_wd_i(dec_wd_i), .dec_store_type_i(dec_store_type_i),
    .dec_load_type_i(dec_load_type_i), .dec_branch_type_i(dec_branch_type_i),
    .dec_branch_target_i(dec_branch_target_i), .dec_jmp_flag_i(dec_jmp_flag_i),
    .dec_jmp_target_i(dec_jmp_target_i), .alu_zero_i(alu_zero_i), .ebreak_i(ebreak_i),
    .lsu_req_o(lsu_req_o), .lsu_we_o(lsu_we_o), .lsu_done_i(lsu_done_i),
    .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o), .commit_o(commit_o),
    .halted_o(halted_o), .err_o(err_o), .inst_cnt_o(inst_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ifu_rvalid_i = 1'b0; ifu_inst_i = '0;
    dec_wd_i = 1'b0; dec_store_type_i = '0; dec_load_type_i = '0;
    dec_branch_type_i = '0; dec_branch_target_i = '0;
    dec_jmp_flag_i = 1'b0; dec_jmp_target_i = '0;
    alu_zero_i = 1'b0; ebreak_i = 1'b0; lsu_done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    m_pc = RST_PC;
    m_cnt = '0;
    rst_n = 1'b1;
  endtask

  // Stopped core must stay stopped and silent.
  task automatic stopped_checks(input string tag, input logic exp_err);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_halted"}, halted_o, 1'b1);
      check({tag, "_err"}, err_o, exp_err);
      check({tag, "_ifu_req"}, ifu_req_o, 1'b0);
      check({tag, "_commit"}, commit_o, 1'b0);
      check({tag, "_reg_we"}, reg_we_o, 1'b0);
      check({tag, "_lsu_req"}, lsu_req_o, 1'b0);
      check({tag, "_cnt"}, inst_cnt_o, m_cnt);
      @(negedge clk);
    end
  endtask

  // One instruction end to end. flat/mlat = fetch and LSU latency in cycles.
  task automatic exec(input logic wd, input logic [1:0] st, input logic [2:0] lt,
                      input logic [2:0] bt, input logic [31:0] btgt,
                      input logic jf, input logic [31:0] jtgt, input logic zero,
                      input logic ebrk, input int flat, input int mlat, input logic abort);
    logic [31:0] inst, exp_next;
    logic exp_mem, exp_lsu_we, exp_reg_we, exp_wb_sel;
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifu_req_o === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    check("ifu_req_wait", 32'(seen), 32'd1);
    if (!seen) return;
    check("pc_at_fetch", pc_o, m_pc);
    check("cnt_at_fetch", inst_cnt_o, m_cnt);

    // Reference behaviour of one instruction.
    if (jf) exp_next = jtgt & ~32'd1;
    else if (bt == 3'd1 && zero) exp_next = btgt;
    else exp_next = m_pc + 32'd4;
    exp_mem    = (st != 0) || (lt != 0);
    exp_lsu_we = (st != 0);
    exp_reg_we = wd && (st == 0);
    exp_wb_sel = (lt != 0);

    inst = $urandom;
    dec_wd_i = wd; dec_store_type_i = st; dec_load_type_i = lt;
    dec_branch_type_i = bt; dec_branch_target_i = btgt;
    dec_jmp_flag_i = jf; dec_jmp_target_i = jtgt; alu_zero_i = zero; ebreak_i = ebrk;

    for (int k = 1; k <= flat; k++) begin
      check("if_req_hold", ifu_req_o, 1'b1);
      check("if_commit", commit_o, 1'b0);
      ifu_rvalid_i = (k == flat);
      ifu_inst_i = (k == flat) ? inst : $urandom;
      @(negedge clk);
    end
    ifu_rvalid_i = 1'b0;
    // ID
    check("id_ifu_req", ifu_req_o, 1'b0);
    check("id_inst", inst_o, inst);
    check("id_commit", commit_o, 1'b0);
    @(negedge clk);
    if (ebrk) begin
      ebreak_i = 1'b0;
      stopped_checks("halt", 1'b0);
      return;
    end
    // EX
    check("ex_commit", commit_o, 1'b0);
    check("ex_lsu_req", lsu_req_o, 1'b0);
    check("ex_halted", halted_o, 1'b0);
    @(negedge clk);
    if (exp_next[1:0] != 2'b00) begin
      stopped_checks("err", 1'b1);
      return;
    end
    if (exp_mem) begin
      for (int k = 1; k <= mlat; k++) begin
        check("mem_lsu_req", lsu_req_o, 1'b1);
        check("mem_lsu_we", lsu_we_o, exp_lsu_we);
        check("mem_reg_we", reg_we_o, 1'b0);
        check("mem_commit", commit_o, 1'b0);
        if (abort && k == 2) begin
          rst_n = 1'b0;
          #1;
          check("rst_lsu_req", lsu_req_o, 1'b0);
          check("rst_pc", pc_o, RST_PC);
          check("rst_cnt", inst_cnt_o, 32'd0);
          check("rst_inst", inst_o, 32'd0);
          check("rst_halted", halted_o, 1'b0);
          check("rst_err", err_o, 1'b0);
          clear_inputs();
          m_pc = RST_PC;
          m_cnt = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        lsu_done_i = (k == mlat);
        @(negedge clk);
      end
      lsu_done_i = 1'b0;
    end
    // WB
    check("wb_commit", commit_o, 1'b1);
    check("wb_reg_we", reg_we_o, exp_reg_we);
    check("wb_sel", wb_sel_o, exp_wb_sel);
    check("wb_lsu_req", lsu_req_o, 1'b0);
    check("wb_ifu_req", ifu_req_o, 1'b0);
    m_pc = exp_next;
    m_cnt = m_cnt + 32'd1;
    @(negedge clk);
    clear_inputs();
    check("post_commit", commit_o, 1'b0);
  endtask

  task automatic random_instr();
    logic [31:0] kind, r, base, btgt, jtgt;
    logic [1:0] st;
    logic [2:0] lt, bt;
    logic wd, zero;
    int flat, mlat;
    kind = $urandom_range(0, 4);
    wd = 1'($urandom); zero = 1'($urandom);
    st = 2'd0; lt = 3'd0; bt = 3'd0; btgt = $urandom; jtgt = '0;
    flat = $urandom_range(1, 3); mlat = $urandom_range(1, 3);
    case (kind)
      0: ;
      1: begin
        st = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) lt = 3'($urandom_range(1, 7));
      end
      2: lt = 3'($urandom_range(1, 7));
      3: begin
        wd = 1'b0;
        bt = 3'($urandom_range(0, 3));
        r = $urandom_range(0, 63);
        base = m_pc + (r << 2) - 32'd128;
        // Misaligned targets only where the branch is not taken.
        if (bt == 3'd1 && zero) btgt = base;
        else btgt = base | 32'($urandom_range(0, 3));
      end
      default: begin
        wd = 1'b1;
        bt = 3'd1; zero = 1'b1; btgt = 32'h8000_0400;
        r = $urandom_range(0, 255);
        jtgt = 32'h8000_0000 + (r << 2) + 32'($urandom_range(0, 1));
        exec(wd, st, lt, bt, btgt, 1'b1, jtgt, zero, 1'b0, flat, mlat, 1'b0);
        return;
      end
    endcase
    exec(wd, st, lt, bt, btgt, 1'b0, jtgt, zero, 1'b0, flat, mlat, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m_pc = RST_PC;
    m_cnt = '0;
    repeat (2) @(negedge clk);
    check("reset_pc", pc_o, RST_PC);
    check("reset_inst", inst_o, 32'd0);
    check("reset_cnt", inst_cnt_o, 32'd0);
    check("reset_ifu_req", ifu_req_o, 1'b0);
    check("reset_lsu_req", lsu_req_o, 1'b0);
    check("reset_commit", commit_o, 1'b0);
    check("reset_flags", {30'd0, halted_o, err_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_to_if", ifu_req_o, 1'b1);

    // addi, 2-cycle fetch
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 2, 1, 1'b0);
    check("addi_pc", pc_o, 32'h8000_0004);
    check("addi_cnt", inst_cnt_o, 32'd1);
    // sw, 3-cycle LSU
    exec(1'b0, 2'd2, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 3, 1'b0);
    // lw
    exec(1'b1, 2'd0, 3'd2, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 2, 1'b0);
    // beq taken / not taken
    exec(1'b0, 2'd0, 3'd0, 3'd1, 32'h8000_0010, 1'b0, 32'd0, 1'b1, 1'b0, 1, 1, 1'b0);
    exec(1'b0, 2'd0, 3'd0, 3'd1, 32'h8000_0010, 1'b0, 32'd0, 1'b0, 1'b0, 1, 1, 1'b0);
    // jalr with odd target
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b1, 32'h8000_0101, 1'b0, 1'b0, 1, 1, 1'b0);
    check("jalr_pc", pc_o, 32'h8000_0100);
    // PC wrap through 0xFFFFFFFC
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1, 1, 1'b0);
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 1, 1'b0);
    check("wrap_pc", pc_o, 32'h0000_0000);
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 1, 1, 1'b0);

    for (int i = 0; i < 60; i++) random_instr();

    // Misaligned jump -> ERR
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b1, 32'h8000_0102, 1'b0, 1'b0, 1, 1, 1'b0);
    do_reset();
    // ebreak -> HALT
    exec(1'b1, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 1, 1'b0);
    exec(1'b0, 2'd0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 2, 1, 1'b0);
    do_reset();
    // Reset during MEM wait, then resume normally
    exec(1'b0, 2'd1, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 4, 1'b1);
    exec(1'b1, 2'd0, 3'd3, 3'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1, 1, 1'b0);
    check("resume_pc", pc_o, 32'h8000_0004);
    check("resume_cnt", inst_cnt_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
